// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit bus writer: sends one byte (or a single init nibble) with
// setup/pulse/hold timing on LCD_E, then stays busy for the controller's execution time.
module lcd_nibble_writer #(
  parameter int CLK_FREQ     = 50000000,
  parameter int SETUP_US     = 1,
  parameter int PULSE_US     = 1,
  parameter int HOLD_US      = 1,
  parameter int CMD_WAIT_US  = 50,
  parameter int LONG_WAIT_US = 2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       nibble_only,
  output logic       busy,
  output logic       done,
  output logic [4:0] LCD_D,
  output logic       LCD_E
);

  localparam int CPU  = CLK_FREQ / 1000000;
  localparam int S    = SETUP_US * CPU;
  localparam int P    = PULSE_US * CPU;
  localparam int H    = HOLD_US * CPU;
  localparam int W    = CMD_WAIT_US * CPU;
  localparam int LW   = LONG_WAIT_US * CPU;
  localparam int M1   = (S > P) ? S : P;
  localparam int M2   = (M1 > H) ? M1 : H;
  localparam int M3   = (M2 > W) ? M2 : W;
  localparam int MAXC = (M3 > LW) ? M3 : LW;
  localparam int CW   = $clog2(MAXC + 1);

  // Counters are loaded with duration-1 so each state lasts exactly its count.
  localparam logic [CW-1:0] S_LD  = CW'(S - 1);
  localparam logic [CW-1:0] P_LD  = CW'(P - 1);
  localparam logic [CW-1:0] H_LD  = CW'(H - 1);
  localparam logic [CW-1:0] W_LD  = CW'(W - 1);
  localparam logic [CW-1:0] LW_LD = CW'(LW - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP_HI, ST_PULSE_HI, ST_HOLD_HI,
    ST_SETUP_LO, ST_PULSE_LO, ST_HOLD_LO, ST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    lcd_d_q, lcd_d_d;
  logic          lcd_e_q, lcd_e_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;

  logic [3:0]    lo_q;
  logic          rs_q, nib_q, long_q;
  logic [CW-1:0] wait_ld;

  assign wait_ld = long_q ? LW_LD : W_LD;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcd_d_d = lcd_d_q;
    lcd_e_d = lcd_e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        accept  = 1'b1;
        state_d = ST_SETUP_HI;
        cnt_d   = S_LD;
        lcd_d_d = {rs, data[7:4]};
        lcd_e_d = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (state_q)
        ST_SETUP_HI: begin state_d = ST_PULSE_HI; cnt_d = P_LD; lcd_e_d = 1'b1; end
        ST_PULSE_HI: begin state_d = ST_HOLD_HI;  cnt_d = H_LD; lcd_e_d = 1'b0; end
        ST_HOLD_HI: begin
          if (nib_q) begin
            state_d = ST_WAIT;
            cnt_d   = wait_ld;
          end else begin
            state_d = ST_SETUP_LO;
            cnt_d   = S_LD;
            lcd_d_d = {rs_q, lo_q};
          end
        end
        ST_SETUP_LO: begin state_d = ST_PULSE_LO; cnt_d = P_LD; lcd_e_d = 1'b1; end
        ST_PULSE_LO: begin state_d = ST_HOLD_LO;  cnt_d = H_LD; lcd_e_d = 1'b0; end
        ST_HOLD_LO:  begin state_d = ST_WAIT;     cnt_d = wait_ld; end
        ST_WAIT: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lcd_d_q <= 5'd0;
      lcd_e_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcd_d_q <= lcd_d_d;
      lcd_e_q <= lcd_e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Transaction fields are only read after accept, so they need no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lo_q   <= data[3:0];
      rs_q   <= rs;
      nib_q  <= nibble_only;
      long_q <= !rs && !nibble_only &&
                (data == 8'h01 || data == 8'h02 || data == 8'h03);
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign LCD_D = lcd_d_q;
  assign LCD_E = lcd_e_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: table vectors, randomized writes and hand-written corner
// sequences, all checked against a timeline model derived from the write rules.
module tb_lcd_nibble_writer;

  localparam int TB_CLK = 2000000;
  localparam int SU = 1, PU = 2, HU = 3, CU = 50, LU = 2000;
  localparam int CPU   = TB_CLK / 1000000;
  localparam int S     = SU * CPU;
  localparam int P     = PU * CPU;
  localparam int H     = HU * CPU;
  localparam int W     = CU * CPU;
  localparam int LW    = LU * CPU;
  localparam int SEG   = S + P + H;
  localparam int FULL  = 2 * SEG + W;
  localparam int LONGT = 2 * SEG + LW;
  localparam int NIBT  = SEG + W;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rs = 1'b0;
  logic       nibble_only = 1'b0;
  logic       busy, done, LCD_E;
  logic [4:0] LCD_D;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_nibble_writer #(
    .CLK_FREQ(TB_CLK), .SETUP_US(SU), .PULSE_US(PU), .HOLD_US(HU),
    .CMD_WAIT_US(CU), .LONG_WAIT_US(LU)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .data(data), .rs(rs),
    .nibble_only(nibble_only), .busy(busy), .done(done), .LCD_D(LCD_D), .LCD_E(LCD_E)
  );

  always #5 CLK = ~CLK;

  function automatic bit is_long(logic [7:0] d, logic r, logic nb);
    return !r && !nb && (d >= 8'd1) && (d <= 8'd3);
  endfunction

  function automatic int txn_len(logic [7:0] d, logic r, logic nb);
    return (nb ? 1 : 2) * SEG + (is_long(d, r, nb) ? LW : W);
  endfunction

  // Expected {busy, done, E, D[4:0]} n edges after the accept edge (n <= length).
  function automatic logic [7:0] model(int n, logic [7:0] d, logic r, logic nb);
    int nn, tot, k, m;
    logic [4:0] last;
    logic [3:0] nib;
    nn   = nb ? 1 : 2;
    tot  = txn_len(d, r, nb);
    last = {r, nb ? d[7:4] : d[3:0]};
    if (n >= tot) return {1'b0, (n == tot), 1'b0, last};
    if (n < nn * SEG) begin
      k   = n / SEG;
      m   = n % SEG;
      nib = (k == 0) ? d[7:4] : d[3:0];
      return {1'b1, 1'b0, (m >= S && m < S + P), r, nib};
    end
    return {1'b1, 1'b0, 1'b0, last};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called just after a negedge; leaves the bench at the negedge of the done cycle.
  task automatic run_txn(string tag, logic [7:0] d, logic r, logic nb, int exp_lat, int exp_pulses);
    int tot, lat, pulses, bad, first_n;
    logic [7:0] act, exp, first_act, first_exp;
    logic prev_e;
    tot = txn_len(d, r, nb);
    data = d; rs = r; nibble_only = nb; start = 1'b1;
    @(posedge CLK);
    lat = -1; pulses = 0; bad = 0; first_n = -1; prev_e = 1'b0;
    first_act = 8'h00; first_exp = 8'h00;
    for (int n = 0; n <= tot; n++) begin
      @(negedge CLK);
      act = {busy, done, LCD_E, LCD_D};
      exp = model(n, d, r, nb);
      if (act !== exp) begin
        if (bad == 0) begin first_n = n; first_act = act; first_exp = exp; end
        bad++;
      end
      if (done === 1'b1 && lat < 0) lat = n;
      if (LCD_E === 1'b1 && prev_e !== 1'b1) pulses++;
      prev_e = LCD_E;
      start       = (n == 10 || n == tot - 20);
      data        = 8'($urandom);
      rs          = 1'($urandom_range(0, 1));
      nibble_only = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL wave_%s: %0d bad cycles, first n=%0d got %h expected %h",
               tag, bad, first_n, first_act, first_exp);
    end
    chk({"latency_", tag}, lat, exp_lat);
    chk({"pulses_", tag}, pulses, exp_pulses);
  endtask

  task automatic idle_check(string name, int cycles);
    int act;
    act = 0;
    start = 1'b0;
    repeat (cycles) begin
      @(negedge CLK);
      if ({busy, done, LCD_E} !== 3'b000) act++;
    end
    chk(name, act, 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       r;
    logic       nb;
    int         lat;
    int         pulses;
    string      tag;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [7:0] rd;
    logic rr, rn;
    int cnt;

    tbl[0]  = '{8'h41, 1'b1, 1'b0, FULL,  2, "data41"};
    tbl[1]  = '{8'h01, 1'b0, 1'b0, LONGT, 2, "clear"};
    tbl[2]  = '{8'h02, 1'b0, 1'b0, LONGT, 2, "home"};
    tbl[3]  = '{8'h03, 1'b0, 1'b0, LONGT, 2, "cmd03"};
    tbl[4]  = '{8'h06, 1'b0, 1'b0, FULL,  2, "entry06"};
    tbl[5]  = '{8'h04, 1'b0, 1'b0, FULL,  2, "cmd04"};
    tbl[6]  = '{8'h00, 1'b0, 1'b0, FULL,  2, "cmd00"};
    tbl[7]  = '{8'h01, 1'b1, 1'b0, FULL,  2, "data01"};
    tbl[8]  = '{8'h30, 1'b0, 1'b1, NIBT,  1, "init30"};
    tbl[9]  = '{8'h01, 1'b0, 1'b1, NIBT,  1, "nib01"};
    tbl[10] = '{8'hFF, 1'b1, 1'b0, FULL,  2, "dataFF"};

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("in_reset_E", LCD_E, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_E", LCD_E, 0);
    chk("rst_D", LCD_D, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge CLK);
      if ({busy, done, LCD_E, LCD_D} !== 8'h00) cnt++;
    end
    chk("idle_activity", cnt, 0);

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].tag, tbl[i].d, tbl[i].r, tbl[i].nb, tbl[i].lat, tbl[i].pulses);
      idle_check({"gap_", tbl[i].tag}, 3);
    end

    // Back-to-back: each new start is raised in the previous write's done cycle.
    run_txn("b2b0", 8'h41, 1'b1, 1'b0, FULL, 2);
    run_txn("b2b1", 8'h28, 1'b1, 1'b0, FULL, 2);
    run_txn("b2b2", 8'h30, 1'b0, 1'b1, NIBT, 1);
    run_txn("b2b3", 8'h01, 1'b0, 1'b0, LONGT, 2);
    idle_check("gap_b2b", 3);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) rd = 8'($urandom_range(1, 3));
      else rd = 8'($urandom);
      rr = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 3) == 0);
      run_txn($sformatf("rnd%0d", i), rd, rr, rn, txn_len(rd, rr, rn), rn ? 1 : 2);
      if (i % 2 == 0) idle_check($sformatf("gap_rnd%0d", i), 2);
    end

    // Reset in the middle of the first E pulse.
    data = 8'h41; rs = 1'b1; nibble_only = 1'b0; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (S) @(negedge CLK);
    chk("pre_rst_E", LCD_E, 1);
    #2 RST = 1'b1;
    #1;
    chk("midrst_E", LCD_E, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_D", LCD_D, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle_check("post_rst_idle", 20);
    run_txn("after_rst", 8'h41, 1'b1, 1'b0, FULL, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
